// File: rtl/rx_header_assembler.sv
// Packs UART receive bytes into one wide block header and hands it off over valid/ready.
// Define HDR_XOR_CHECK_EN to require a trailing XOR checksum byte (adds the err_csum port).
module rx_header_assembler #(
    parameter int NUM_BYTES = 80,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_data_ready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_endofpacket,
    output logic                   hdr_valid,
    input  logic                   hdr_ready,
    output logic [NUM_BYTES*8-1:0] hdr_data,
    output logic [CNT_W-1:0]       byte_count,
    output logic                   err_short,
    output logic                   err_overrun
`ifdef HDR_XOR_CHECK_EN
    ,
    output logic                   err_csum
`endif
);

    localparam int HW = NUM_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BYTES);

    typedef enum logic {
        COLLECT,
        FULL
    } state_e;

    state_e           state_q;
    logic [HW-1:0]    hdr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             short_q;
    logic             ovr_q;
`ifdef HDR_XOR_CHECK_EN
    logic [7:0]       xor_q;
    logic             csum_q;
`endif

    logic [CNT_W-1:0] slot_d;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             hs_d;

    // Slot 0 lives in the most significant byte lane.
    assign slot_d    = LAST_CNT - cnt_q;
    assign cnt_inc_d = cnt_q + 1'b1;
    assign hs_d      = valid_q & hdr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            hdr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef HDR_XOR_CHECK_EN
            xor_q   <= '0;
            csum_q  <= 1'b0;
`endif
        end else begin
            short_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef HDR_XOR_CHECK_EN
            csum_q  <= 1'b0;
`endif
            unique case (state_q)
                COLLECT: begin
`ifdef HDR_XOR_CHECK_EN
                    if (rx_data_ready && cnt_q == FULL_CNT) begin
                        xor_q <= '0;
                        if (rx_data == xor_q) begin
                            state_q <= FULL;
                            valid_q <= 1'b1;
                        end else begin
                            csum_q <= 1'b1;
                            cnt_q  <= '0;
                        end
                    end else if (rx_data_ready) begin
                        for (int i = 0; i < NUM_BYTES; i++) begin
                            if (slot_d == CNT_W'(i)) begin
                                hdr_q[i*8 +: 8] <= rx_data;
                            end
                        end
                        if (rx_endofpacket) begin
                            short_q <= 1'b1;
                            cnt_q   <= '0;
                            xor_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc_d;
                            xor_q <= xor_q ^ rx_data;
                        end
                    end else if (rx_endofpacket && cnt_q != '0) begin
                        short_q <= 1'b1;
                        cnt_q   <= '0;
                        xor_q   <= '0;
                    end
`else
                    if (rx_data_ready) begin
                        for (int i = 0; i < NUM_BYTES; i++) begin
                            if (slot_d == CNT_W'(i)) begin
                                hdr_q[i*8 +: 8] <= rx_data;
                            end
                        end
                        if (cnt_q == LAST_CNT) begin
                            state_q <= FULL;
                            valid_q <= 1'b1;
                            cnt_q   <= FULL_CNT;
                        end else if (rx_endofpacket) begin
                            short_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end else if (rx_endofpacket && cnt_q != '0) begin
                        short_q <= 1'b1;
                        cnt_q   <= '0;
                    end
`endif
                end
                FULL: begin
                    if (hs_d) begin
                        state_q <= COLLECT;
                        valid_q <= 1'b0;
                        // A byte arriving with the handshake starts the next packet.
                        if (rx_data_ready) begin
                            hdr_q[HW-1 -: 8] <= rx_data;
                            cnt_q            <= CNT_W'(1);
`ifdef HDR_XOR_CHECK_EN
                            xor_q            <= rx_data;
`endif
                        end else begin
                            cnt_q <= '0;
`ifdef HDR_XOR_CHECK_EN
                            xor_q <= '0;
`endif
                        end
                    end else if (rx_data_ready) begin
                        ovr_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign hdr_valid   = valid_q;
    assign hdr_data    = hdr_q;
    assign byte_count  = cnt_q;
    assign err_short   = short_q;
    assign err_overrun = ovr_q;
`ifdef HDR_XOR_CHECK_EN
    assign err_csum    = csum_q;
`endif

endmodule

// File: tb/tb_rx_header_assembler.sv
// Scoreboard bench for rx_header_assembler with a 4-byte header.
// Headers and error pulses are queued by stimulus and consumed by a negedge monitor.
module tb_rx_header_assembler;

    localparam int NB = 4;
    localparam int EC_SHORT = 1;
    localparam int EC_OVR   = 2;
    localparam int EC_CSUM  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_data_ready = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_endofpacket = 1'b0;
    logic          hdr_valid;
    logic          hdr_ready = 1'b0;
    logic [NB*8-1:0] hdr_data;
    logic [7:0]    byte_count;
    logic          err_short;
    logic          err_overrun;
`ifdef HDR_XOR_CHECK_EN
    logic          err_csum;
`endif

    int total = 0;
    int bad = 0;
    int valid_cycles = 0;
    logic [31:0] exp_hdr[$];
    int          exp_err[$];
    logic prev_short = 1'b0;
    logic prev_ovr = 1'b0;
    logic prev_csum = 1'b0;

    rx_header_assembler #(.NUM_BYTES(NB), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data_ready(rx_data_ready),
        .rx_data(rx_data),
        .rx_endofpacket(rx_endofpacket),
        .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready),
        .hdr_data(hdr_data),
        .byte_count(byte_count),
        .err_short(err_short),
        .err_overrun(err_overrun)
`ifdef HDR_XOR_CHECK_EN
        ,
        .err_csum(err_csum)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_err(input string nm, input int code, input logic prev);
        int e;
        chk({nm, "_width"}, 64'(prev), 64'd0);
        if (exp_err.size() == 0) begin
            chk({nm, "_unexpected"}, 64'(code), 64'd0);
        end else begin
            e = exp_err.pop_front();
            chk(nm, 64'(code), 64'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (hdr_valid) valid_cycles++;
            if (hdr_valid && hdr_ready) begin
                if (exp_hdr.size() == 0) chk("hdr_unexpected", 64'(hdr_data), 64'd0);
                else chk("hdr_data", 64'(hdr_data), 64'(exp_hdr.pop_front()));
            end
            if (err_short) chk_err("err_short", EC_SHORT, prev_short);
            if (err_overrun) chk_err("err_overrun", EC_OVR, prev_ovr);
`ifdef HDR_XOR_CHECK_EN
            if (err_csum) chk_err("err_csum", EC_CSUM, prev_csum);
            prev_csum = err_csum;
`endif
        end
        prev_short = err_short;
        prev_ovr = err_overrun;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic strobe(input logic [7:0] b, input logic eop);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_data_ready = 1'b1;
        rx_endofpacket = eop;
        @(posedge clk);
        #1;
        rx_data_ready = 1'b0;
        rx_endofpacket = 1'b0;
    endtask

    task automatic eop_pulse();
        @(posedge clk);
        #1;
        rx_endofpacket = 1'b1;
        @(posedge clk);
        #1;
        rx_endofpacket = 1'b0;
    endtask

    function automatic logic [7:0] xsum(input logic [31:0] h);
        return h[31:24] ^ h[23:16] ^ h[15:8] ^ h[7:0];
    endfunction

    task automatic send_hdr(input logic [31:0] h, input int gap);
        for (int i = 0; i < NB; i++) begin
            if (i > 0) idle(gap);
            strobe(h[31-8*i -: 8], 1'b0);
        end
`ifdef HDR_XOR_CHECK_EN
        idle(gap);
        strobe(xsum(h), 1'b0);
`endif
    endtask

    initial begin
        #2;
        chk("rst_valid", 64'(hdr_valid), 64'd0);
        chk("rst_count", 64'(byte_count), 64'd0);
        chk("rst_data", 64'(hdr_data), 64'd0);
        chk("rst_errs", 64'({err_short, err_overrun}), 64'd0);
        idle(2);
        #1;
        rst_n = 1'b1;
        hdr_ready = 1'b1;

        // basic header, slow strobes, consumer always ready
        valid_cycles = 0;
        exp_hdr.push_back(32'h11223344);
        send_hdr(32'h11223344, 10);
        chk("t1_latency_valid", 64'(hdr_valid), 64'd1);
        chk("t1_count_full", 64'(byte_count), 64'd4);
        idle(3);
        chk("t1_valid_cycles", 64'(valid_cycles), 64'd1);
        chk("t1_count_zero", 64'(byte_count), 64'd0);

        // short packet then good packet
        strobe(8'hAA, 1'b0);
        strobe(8'hBB, 1'b0);
        exp_err.push_back(EC_SHORT);
        eop_pulse();
        chk("t2_count_after_short", 64'(byte_count), 64'd0);
        eop_pulse();
        chk("t2_idle_eop_count", 64'(byte_count), 64'd0);
        exp_hdr.push_back(32'h01020304);
        send_hdr(32'h01020304, 1);
        idle(3);

        // byte and eop together below the last slot
        strobe(8'hC1, 1'b0);
        exp_err.push_back(EC_SHORT);
        strobe(8'hC2, 1'b1);
        chk("t2b_count", 64'(byte_count), 64'd0);
        idle(2);

        // byte and eop together on the final byte
        strobe(8'hA1, 1'b0);
        strobe(8'hA2, 1'b0);
        strobe(8'hA3, 1'b0);
`ifdef HDR_XOR_CHECK_EN
        exp_err.push_back(EC_SHORT);
        strobe(8'hA4, 1'b1);
        chk("t2c_valid", 64'(hdr_valid), 64'd0);
`else
        exp_hdr.push_back(32'hA1A2A3A4);
        strobe(8'hA4, 1'b1);
        chk("t2c_valid", 64'(hdr_valid), 64'd1);
`endif
        idle(3);

        // overrun while header pending
        hdr_ready = 1'b0;
        exp_hdr.push_back(32'hDEADBEEF);
        send_hdr(32'hDEADBEEF, 0);
        idle(2);
        exp_err.push_back(EC_OVR);
        strobe(8'h55, 1'b0);
        chk("t3_valid_held", 64'(hdr_valid), 64'd1);
        chk("t3_data_held", 64'(hdr_data), 64'hDEADBEEF);
        chk("t3_count", 64'(byte_count), 64'd4);
        idle(2);

        // handshake together with first byte of the next packet
        @(posedge clk);
        #1;
        hdr_ready = 1'b1;
        rx_data = 8'h77;
        rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_data_ready = 1'b0;
        chk("t4_count_one", 64'(byte_count), 64'd1);
        chk("t4_valid_low", 64'(hdr_valid), 64'd0);
        exp_hdr.push_back(32'h778899AA);
        strobe(8'h88, 1'b0);
        strobe(8'h99, 1'b0);
        strobe(8'hAA, 1'b0);
`ifdef HDR_XOR_CHECK_EN
        strobe(xsum(32'h778899AA), 1'b0);
`endif
        idle(3);

        // reset mid-packet
        strobe(8'h61, 1'b0);
        strobe(8'h62, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_count", 64'(byte_count), 64'd0);
        chk("t5_rst_data", 64'(hdr_data), 64'd0);
        chk("t5_rst_flags", 64'({hdr_valid, err_short, err_overrun}), 64'd0);
        idle(2);
        #1;
        rst_n = 1'b1;
        exp_hdr.push_back(32'h01020304);
        send_hdr(32'h01020304, 0);
        idle(3);

`ifdef HDR_XOR_CHECK_EN
        exp_hdr.push_back(32'h01020408);
        strobe(8'h01, 1'b0);
        strobe(8'h02, 1'b0);
        strobe(8'h04, 1'b0);
        strobe(8'h08, 1'b0);
        strobe(8'h0F, 1'b0);
        chk("t6_valid", 64'(hdr_valid), 64'd1);
        idle(3);
        strobe(8'h01, 1'b0);
        strobe(8'h02, 1'b0);
        strobe(8'h04, 1'b0);
        strobe(8'h08, 1'b0);
        exp_err.push_back(EC_CSUM);
        strobe(8'h0E, 1'b0);
        chk("t7_valid_low", 64'(hdr_valid), 64'd0);
        chk("t7_count", 64'(byte_count), 64'd0);
        idle(3);
        chk("t7_valid_still_low", 64'(hdr_valid), 64'd0);
`endif

        idle(2);
        chk("hdr_queue_empty", 64'(exp_hdr.size()), 64'd0);
        chk("err_queue_empty", 64'(exp_err.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
